// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD    = 4;
  localparam int unsigned DEFAULT_MEM_BYTES = 128;

  // Big-endian byte k of a word (k=0 is the most significant byte).
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide, big-endian memory port.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (running sum of loaded words).
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       word_count,
  output logic [31:0]       checksum
);

  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0] LAST_BYTE = CMP_W'(MEM_BYTES - 1);
  localparam logic [CMP_W-1:0] WORD_SPAN = CMP_W'(BYTES_PER_WORD - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         word_q, word_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [31:0]         count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                fits_c;
  logic                load_start_c;
  logic                word_done_c;

  // Overflow test done one bit wider so ptr+3 never wraps.
  assign fits_c       = (({1'b0, ptr_q} + WORD_SPAN) <= LAST_BYTE);
  assign load_start_c = (state_q == IDLE) && start;
  assign word_done_c  = (state_q == WRITE) && (idx_q == 2'd3);

  assign s_ready    = (state_q == ACCEPT);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign word_count = count_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and next-output logic; the write port is registered one cycle ahead.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = base_addr & ~ADDR_W'(BYTES_PER_WORD - 1);
          err_d   = 1'b0;
          count_d = '0;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        if (s_valid) begin
          word_d = s_data;
          last_d = s_last;
          if (fits_c) begin
            idx_d   = 2'd0;
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = word_byte(s_data, 2'd0);
            state_d = WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          we_d    = 1'b1;
          addr_d  = ptr_q + ADDR_W'(idx_d);
          wdata_d = word_byte(word_q, idx_d);
        end else begin
          ptr_d   = ptr_q + ADDR_W'(BYTES_PER_WORD);
          count_d = count_q + 32'd1;
          state_d = last_q ? DONE : ACCEPT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  // Wrap-around sum of written words, updated alongside word_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (load_start_c) begin
      sum_q <= '0;
    end else if (word_done_c) begin
      sum_q <= sum_q + word_q;
    end
  end

  assign checksum = sum_q;
`else
  logic unused_c;
  assign unused_c = load_start_c ^ word_done_c;
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table of loads plus hand-written corner sequences.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] word_count;
  logic [31:0] checksum;

  imem_loader #(.MEM_BYTES(128), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_err;
    logic [31:0] exp_count;
    logic [31:0] exp_sum;
  } vec_t;

  wr_t         exp_q[$];
  logic [7:0]  mem [128];
  logic [31:0] mptr;
  logic        merr;
  int          checks;
  int          fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every byte write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", {24'b0, mem_wdata}, {24'b0, e.data});
      end
      if (mem_addr < 32'd128) mem[mem_addr[6:0]] = mem_wdata;
    end
  end

  task automatic check_reset_vals();
    check("rst_s_ready", {31'b0, s_ready}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_word_count", word_count, 32'd0);
    check("rst_checksum", checksum, 32'd0);
  endtask

  // Start a load; returns on the first negedge in ACCEPT.
  task automatic do_start(input logic [31:0] base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    mptr = base & ~32'd3;
    merr = 1'b0;
    @(negedge clk);
    start = 1'b0;
    base_addr = $urandom;
    check("start_s_ready", {31'b0, s_ready}, 32'd1);
    check("start_busy", {31'b0, busy}, 32'd1);
    check("start_err_clear", {31'b0, err}, 32'd0);
    check("start_count_clear", word_count, 32'd0);
  endtask

  // Hand one word over; returns on the negedge where done is expected (if the load ends).
  task automatic send_word(input logic [31:0] d, input logic lst, input logic pulse, output logic ended);
    int   g;
    logic fits;
    g = 0;
    while (s_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("s_ready_wait", {31'b0, s_ready}, 32'd1);
    fits = ({1'b0, mptr} + 33'd3) <= 33'd127;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = lst;
    if (fits) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({mptr + 32'(k), d[31-8*k -: 8]});
      mptr = mptr + 32'd4;
    end else begin
      merr = 1'b1;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = $urandom;
    if (!fits) begin
      @(negedge clk);
      check("ovf_done", {31'b0, done}, 32'd1);
      check("ovf_err", {31'b0, err}, 32'd1);
      ended = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        check("write_window", {31'b0, mem_we}, 32'd1);
        if (pulse && k == 2) begin
          start = 1'b1;
          base_addr = 32'd0;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      if (lst) check("last_done", {31'b0, done}, 32'd1);
      else     check("next_ready", {31'b0, s_ready}, 32'd1);
      check("write_end", {31'b0, mem_we}, 32'd0);
      ended = lst;
    end
  endtask

  // Called on the done negedge; verifies results and return to IDLE.
  task automatic finish_load(input logic exp_err, input logic [31:0 ] exp_count, input logic [31:0] exp_sum);
    check("end_err", {31'b0, err}, {31'b0, exp_err});
    check("end_err_model", {31'b0, err}, {31'b0, merr});
    check("end_count", word_count, exp_count);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("end_checksum", checksum, exp_sum);
`else
    check("end_checksum", checksum, (exp_sum & 32'd0));
`endif
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_done", {31'b0, done}, 32'd0);
    check("idle_err_sticky", {31'b0, err}, {31'b0, exp_err});
  endtask

  function automatic logic [31:0] read_word(input logic [31:0] a);
    return {mem[a[6:0]], mem[a[6:0] + 7'd1], mem[a[6:0] + 7'd2], mem[a[6:0] + 7'd3]};
  endfunction

  vec_t vecs[6];

  initial begin
    logic ended;
    checks = 0;
    fails  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    mptr = '0;
    merr = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    vecs[0] = '{32'h0000_0000, 2, 32'h2002_0001, 32'h2003_0002, 1'b0, 32'd2, 32'h4005_0003};
    vecs[1] = '{32'h0000_007C, 2, 32'h1111_1111, 32'h2222_2222, 1'b1, 32'd1, 32'h1111_1111};
    vecs[2] = '{32'h0000_000A, 1, 32'hDEAD_BEEF, 32'h0,        1'b0, 32'd1, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_0040, 2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'd2, 32'h0000_0001};
    vecs[4] = '{32'h0000_0200, 1, 32'hCAFE_F00D, 32'h0,        1'b1, 32'd0, 32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFC, 1, 32'h1234_5678, 32'h0,        1'b1, 32'd0, 32'h0000_0000};

    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // Table-driven loads.
    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].base);
      ended = 1'b0;
      for (int i = 0; i < vecs[v].n && !ended; i++)
        send_word(i == 0 ? vecs[v].w0 : vecs[v].w1, i == vecs[v].n - 1, 1'b0, ended);
      finish_load(vecs[v].exp_err, vecs[v].exp_count, vecs[v].exp_sum);
      for (int i = 0; i < int'(vecs[v].exp_count); i++)
        check("readback", read_word((vecs[v].base & ~32'd3) + 32'(4 * i)), i == 0 ? vecs[v].w0 : vecs[v].w1);
    end

    // Stall in ACCEPT: s_ready stays up, nothing is written.
    do_start(32'h0000_0030);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", {31'b0, s_ready}, 32'd1);
      check("stall_no_we", {31'b0, mem_we}, 32'd0);
    end
    send_word(32'hA5A5_0F0F, 1'b1, 1'b0, ended);
    finish_load(1'b0, 32'd1, 32'hA5A5_0F0F);

    // Start pulsed during WRITE is ignored; second word lands after the first.
    do_start(32'h0000_0020);
    send_word(32'h0102_0304, 1'b0, 1'b1, ended);
    send_word(32'h0506_0708, 1'b1, 1'b0, ended);
    finish_load(1'b0, 32'd2, 32'h0608_0A0C);
    check("start_ignored_rb", read_word(32'h24), 32'h0506_0708);

    // Reset during byte index 2.
    do_start(32'h0000_0050);
    s_valid = 1'b1;
    s_data  = 32'h1122_3344;
    s_last  = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back({32'h50 + 32'(k), s_data[31-8*k -: 8]});
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    check("rst_popped_two", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_no_we", {31'b0, mem_we}, 32'd0);
    end
    rst_n = 1'b1;
    check("rst_partial_rb", {16'b0, mem[7'h50], mem[7'h51]}, 32'h0000_1122);
    do_start(32'h0000_0060);
    send_word(32'h7766_5544, 1'b1, 1'b0, ended);
    finish_load(1'b0, 32'd1, 32'h7766_5544);
    check("after_rst_rb", read_word(32'h60), 32'h7766_5544);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
